// File: rtl/display_pkg.sv
// display_pkg: shared types, widths and range helper for the multiplexed BCD display scanner
package display_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_DIGITS = 4;
  function automatic int bcd_w(input int digits);
    return 4 * (digits + 1);
  endfunction
  localparam int BCD_W = bcd_w(DEF_DIGITS);
  function automatic int max_display(input int digits);
    return 10 ** digits - 1;
  endfunction
endpackage

// File: rtl/display_scanner_bin2bcd.sv
// bin2bcd_seq: iterative double-dabble converter; ports clk, reset, start, bin in, busy, done (final-shift cycle), bcd (result valid with done)
module bin2bcd_seq import display_pkg::*; #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = bcd_w(DIGITS);
  localparam int CW = $clog2(WIDTH + 1);
  state_t              state;
  logic [BW-1:0]       acc;
  logic [BW-1:0]       adj;
  logic [WIDTH-1:0]    sr;
  logic [CW-1:0]       cnt;
  logic [BW+WIDTH-1:0] sh;
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS + 1; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    sh = {adj, sr} << 1;
  end
  // done and bcd reflect the shift being applied at this edge, so the parent can
  // commit the finished result on the same edge the last shift happens
  assign done = state == SHIFT && cnt == CW'(1);
  assign bcd  = sh[WIDTH +: 4*DIGITS];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      acc   <= '0;
      sr    <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        sr    <= bin;
        acc   <= '0;
        cnt   <= CW'(WIDTH);
        state <= SHIFT;
        busy  <= 1'b1;
      end
    end else begin
      acc <= sh[BW+WIDTH-1:WIDTH];
      sr  <= sh[WIDTH-1:0];
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/display_scanner.sv
// display_scanner: converts value to BCD on load and time-multiplexes digits onto one decoder; ports clk, reset, value, load in; busy, overflow, data, out (digit enable), anodes (active-low) out
module display_scanner import display_pkg::*; #(
  parameter int WIDTH       = 14,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic              overflow,
  output logic [3:0]        data,
  output logic              out,
  output logic [DIGITS-1:0] anodes
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [RW-1:0]       rcnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] bcd;
  logic                done;
  logic                ovf_pend;
  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (load),
    .bin   (value),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt     <= '0;
      idx      <= '0;
      disp     <= '0;
      overflow <= 1'b0;
      ovf_pend <= 1'b0;
    end else begin
      rcnt <= rcnt == RW'(REFRESH_DIV - 1) ? '0 : rcnt + RW'(1);
      if (rcnt == RW'(REFRESH_DIV - 1))
        idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      // the range flag is latched at accept and only becomes visible with its result
      if (load && !busy)
        ovf_pend <= 32'(value) > 32'(max_display(DIGITS));
      if (done) begin
        disp     <= bcd;
        overflow <= ovf_pend;
      end
    end
  end
  // shifting by idx nibbles leaves only this digit and the more significant ones
  assign anodes = ~(DIGITS'(1) << idx);
  assign data   = disp[4*idx +: 4];
  assign out    = !overflow && (idx == '0 || (disp >> (4*idx)) != '0);
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: directed self-checking bench for display_scanner with a short refresh period
module tb_display_scanner;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic        busy, overflow, out;
  logic [3:0]  data;
  logic [3:0]  anodes;
  int          vectors = 0;
  int          miscompares = 0;

  display_scanner #(.WIDTH(14), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .busy     (busy),
    .overflow (overflow),
    .data     (data),
    .out      (out),
    .anodes   (anodes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [13:0] v);
    value = v;
    load  = 1'b1;
    tick(1);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      tick(1);
      cycles++;
    end
  endtask

  task automatic show(input string tag, input logic [15:0] digits, input logic [3:0] lit);
    logic [3:0] sel;
    int         n;
    for (int d = 0; d < 4; d++) begin
      sel = ~(4'b0001 << d);
      n = 0;
      while (anodes !== sel && n < 40) begin
        tick(1);
        n++;
      end
      check($sformatf("%s anode%0d", tag, d), 32'(anodes), 32'(sel));
      check($sformatf("%s data%0d", tag, d), 32'(data), 32'(digits[4*d +: 4]));
      check($sformatf("%s out%0d", tag, d), 32'(out), 32'(lit[d]));
    end
  endtask

  initial begin
    int cyc;
    tick(2);
    reset = 1'b0;
    check("rst anodes", 32'(anodes), 32'h0000000e);
    check("rst data", 32'(data), 32'h0);
    check("rst out", 32'(out), 32'h1);
    check("rst busy", 32'(busy), 32'h0);
    check("rst overflow", 32'(overflow), 32'h0);
    tick(4);
    check("scan1 anodes", 32'(anodes), 32'h0000000d);
    check("scan1 out", 32'(out), 32'h0);

    load_val(14'd1234);
    check("1234 busy", 32'(busy), 32'h1);
    wait_idle(cyc);
    check("1234 busy cycles", 32'(cyc), 32'd14);
    show("1234", 16'h1234, 4'b1111);

    load_val(14'd7);
    wait_idle(cyc);
    show("7", 16'h0007, 4'b0001);

    load_val(14'd1005);
    wait_idle(cyc);
    show("1005", 16'h1005, 4'b1111);

    load_val(14'd10000);
    wait_idle(cyc);
    check("10000 overflow", 32'(overflow), 32'h1);
    show("10000", 16'h0000, 4'b0000);

    load_val(14'd9999);
    wait_idle(cyc);
    check("9999 overflow", 32'(overflow), 32'h0);
    show("9999", 16'h9999, 4'b1111);

    load_val(14'd42);
    tick(2);
    load_val(14'd5);
    wait_idle(cyc);
    check("42 remaining busy", 32'(cyc), 32'd11);
    show("42", 16'h0042, 4'b0011);

    load_val(14'd8888);
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'h0);
    check("abort anodes", 32'(anodes), 32'h0000000e);
    check("abort data", 32'(data), 32'h0);
    check("abort out", 32'(out), 32'h1);
    check("abort overflow", 32'(overflow), 32'h0);
    tick(20);
    show("abort", 16'h0000, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Upstream driver for the seven-segment decoder stage.
- Accepts a binary value on a `load` pulse and converts it to BCD with an iterative double-dabble sub-module.
- Time-multiplexes the resulting digits onto one shared decoder: drives its 4-bit `data` and its `out` enable, plus the active-low digit anodes.
- Blanks leading zeros and blanks the whole display when the value is out of range.

Parameters:
- WIDTH, 14, width of the binary input value.
- DIGITS, 4, number of multiplexed digits; the display range is 0 .. 10**DIGITS-1.
- REFRESH_DIV, 50000, clock cycles each digit stays lit (at least 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  WIDTH  binary number to display, sampled on an accepted load.
- load  in  1  request to convert and display `value`; single-cycle pulse or level.
- busy  out  1  high while a conversion is in progress.
- overflow  out  1  high when the displayed value exceeds 10**DIGITS-1.
- data  out  4  BCD digit for the currently selected position; goes to the decoder data input.
- out  out  1  decoder enable; 0 blanks the current digit.
- anodes  out  DIGITS  active-low digit select, one-hot-low.

Behaviour:
- Reset (synchronous, active-high) is dominant over all other inputs:
  - state=IDLE, busy=0, overflow=0, display register=0.
  - Refresh counter=0, digit index idx=0.
  - Outputs after reset: anodes=1110, data=0, out=1 (display shows "0").
- Reset mid-conversion aborts the conversion. The display register returns to 0; the partial result is discarded.
- Conversion FSM, states IDLE and SHIFT:
  - In IDLE, load=1 at edge k is accepted:
    - capture `value` into the shift register; clear the BCD accumulator;
    - iteration count=WIDTH; go to SHIFT;
    - busy=1 from after edge k.
  - Each SHIFT cycle: every BCD nibble >=5 gets +3, then {bcd, bin} shifts left by 1.
  - After exactly WIDTH SHIFT edges (edge k+WIDTH):
    - the BCD result and the overflow flag commit atomically to the display register;
    - state returns to IDLE; busy=0.
  - Latency from load to the new value on the display: WIDTH cycles.
- Overflow:
  - The flag is computed at accept time as value > 10**DIGITS-1.
  - It commits together with the BCD result.
  - The BCD accumulator is 4*(DIGITS+1) bits wide so no carry is lost. Only the low DIGITS nibbles are displayed.
- Load while busy is ignored; there is no queueing. Load held high re-triggers on the first IDLE cycle.
- Scanning runs continuously and independently of conversion:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, idx increments modulo DIGITS; idx 0 is the ones digit.
  - The display never shows a partially converted value.
- Outputs are combinational from registered state only:
  - anodes = ~(1<<idx).
  - data = nibble idx of the display register.
  - out=0 if overflow=1.
  - else out=0 if idx>0 and nibbles idx..DIGITS-1 are all zero (leading-zero blanking).
  - else out=1.
  - Digit 0 is always lit when not in overflow, so a value of 0 shows "0".
  - Interior zeros are shown, e.g. 1005 shows "1005".

Decomposition:
- Package display_pkg holds:
  - the state enum {IDLE, SHIFT};
  - the constant BCD_W = 4*(DIGITS+1);
  - the function max_display(DIGITS) = 10**DIGITS-1.
- Sub-module bin2bcd_seq contains the conversion FSM and the add-3/shift datapath.
  - Ports: clk, reset, start, bin, busy, done, bcd.
- display_scanner instantiates bin2bcd_seq and contains:
  - the refresh counter, idx, display register, blanking logic and anode decode.
- The decoder is instantiated by the parent, not inside this block.

Test Plan (REFRESH_DIV=4, defaults otherwise):
- Reset held 2 cycles, then released -> anodes=1110, data=0, out=1, busy=0, overflow=0. After 4 cycles anodes=1101 with out=0.
- load=1 for one cycle with value=1234 -> busy=1 for exactly 14 cycles. Then each digit lit for 4 cycles:
  - idx0: data=4, out=1;
  - idx1: data=3;
  - idx2: data=2;
  - idx3: data=1;
  - all with out=1 and anodes cycling 1110,1101,1011,0111.
- value=7 -> idx0 data=7, out=1; idx1..3 out=0. Then value=1005 -> all four digits out=1, data 5,0,0,1.
- value=10000 -> overflow=1 and out=0 on every digit. Then load 9999 -> overflow=0 and digits 9,9,9,9.
- load value=42, then load value=5 three cycles later while busy -> second load ignored; the display shows 42 after 14 cycles.
- load value=8888, assert reset at cycle 6 of the conversion -> next cycle busy=0, display register=0, anodes=1110, data=0, out=1.
